// File: rtl/spram_arbiter.sv
// Two-port arbiter for a single-port RAM. Build option: SPRAM_ARB_RR_EN (round-robin on conflicts).
// Latency: gnt combinational; RAM command registered (+1); rvalid/q two cycles after a read grant.
// Backpressure: none beyond gnt; a losing port holds req/we/addr/d until granted.
module spram_arbiter #(
   parameter int aWidth = 10,
   parameter int dWidth = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [1:0]            req,
   input  logic [1:0]            we,
   input  logic [2*aWidth-1:0]   addr,
   input  logic [2*dWidth-1:0]   d,
   output logic [1:0]            gnt,
   output logic [1:0]            rvalid,
   output logic [dWidth-1:0]     q,
   output logic                  ram_we,
   output logic [aWidth-1:0]     ram_addr,
   output logic [dWidth-1:0]     ram_d,
   input  logic [dWidth-1:0]     ram_q
);

   logic [1:0]        gnt_c;
   logic              sel;
   logic              ram_we_q,   ram_we_d;
   logic [aWidth-1:0] ram_addr_q, ram_addr_d;
   logic [dWidth-1:0] ram_d_q,    ram_d_d;
   logic              rd_vld_q,   rd_vld_d;
   logic              rd_id_q,    rd_id_d;
   logic [1:0]        rvalid_q,   rvalid_d;

`ifdef SPRAM_ARB_RR_EN
   logic ptr_q, ptr_d;

   always_comb begin
      gnt_c = req;
      if (req == 2'b11) begin
         gnt_c = ptr_q ? 2'b10 : 2'b01;
      end
      ptr_d = ptr_q;
      // The port just served loses priority on the next conflict.
      if (|gnt) begin
         ptr_d = ~gnt[1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
      end
   end
`else
   always_comb begin
      gnt_c = req;
      if (req == 2'b11) begin
         gnt_c = 2'b01;
      end
   end
`endif

   assign gnt = rst_n ? gnt_c : 2'b00;
   assign sel = gnt[1];

   always_comb begin
      ram_we_d   = 1'b0;
      ram_addr_d = ram_addr_q;
      ram_d_d    = ram_d_q;
      rd_vld_d   = 1'b0;
      rd_id_d    = rd_id_q;
      if (|gnt) begin
         ram_we_d   = sel ? we[1] : we[0];
         ram_addr_d = sel ? addr[2*aWidth-1:aWidth] : addr[aWidth-1:0];
         ram_d_d    = sel ? d[2*dWidth-1:dWidth] : d[dWidth-1:0];
         rd_vld_d   = sel ? ~we[1] : ~we[0];
         rd_id_d    = sel;
      end
      rvalid_d = 2'b00;
      // The RAM returns data one cycle after the address, so the tag flags it then.
      if (rd_vld_q) begin
         rvalid_d = rd_id_q ? 2'b10 : 2'b01;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ram_we_q   <= 1'b0;
         ram_addr_q <= '0;
         ram_d_q    <= '0;
         rd_vld_q   <= 1'b0;
         rd_id_q    <= 1'b0;
         rvalid_q   <= 2'b00;
      end else begin
         ram_we_q   <= ram_we_d;
         ram_addr_q <= ram_addr_d;
         ram_d_q    <= ram_d_d;
         rd_vld_q   <= rd_vld_d;
         rd_id_q    <= rd_id_d;
         rvalid_q   <= rvalid_d;
      end
   end

   assign ram_we   = ram_we_q;
   assign ram_addr = ram_addr_q;
   assign ram_d    = ram_d_q;
   assign rvalid   = rvalid_q;
   assign q        = ram_q;

endmodule

// File: tb/tb_spram_arbiter.sv
// Bench for spram_arbiter: per-port request queues, reference arbiter model, read-data scoreboard.
module tb_spram_arbiter;
   localparam int AW = 10;
   localparam int DW = 8;
`ifdef SPRAM_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   typedef struct packed {
      logic          we;
      logic [AW-1:0] a;
      logic [DW-1:0] dat;
   } cmd_t;

   typedef struct packed {
      logic [31:0]   due;
      logic          p;
      logic [DW-1:0] dat;
   } rd_t;

   logic            clk;
   logic            rst_n;
   logic [1:0]      req;
   logic [1:0]      we;
   logic [2*AW-1:0] addr;
   logic [2*DW-1:0] d;
   logic [1:0]      gnt;
   logic [1:0]      rvalid;
   logic [DW-1:0]   q;
   logic            ram_we;
   logic [AW-1:0]   ram_addr;
   logic [DW-1:0]   ram_d;
   logic [DW-1:0]   ram_q;

   logic [DW-1:0]   mem    [0:(1<<AW)-1];
   logic [DW-1:0]   shadow [0:(1<<AW)-1];

   cmd_t pq0[$];
   cmd_t pq1[$];
   rd_t  sb[$];

   int          total;
   int          bad;
   logic [31:0] cyc;
   logic        mptr;
   logic        m_we;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_d;

   spram_arbiter #(.aWidth(AW), .dWidth(DW)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .d(d),
      .gnt(gnt), .rvalid(rvalid), .q(q), .ram_we(ram_we), .ram_addr(ram_addr),
      .ram_d(ram_d), .ram_q(ram_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single-port RAM, one-cycle read latency, write-first.
   initial begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= '0;
   end
   always @(posedge clk) begin
      if (ram_we) begin
         mem[ram_addr] <= ram_d;
         ram_q         <= ram_d;
      end else begin
         ram_q <= mem[ram_addr];
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s at cycle %0d: got=%0h expected=%0h", tag, cyc, got, exp);
      end
   endtask

   task automatic push_cmd(input bit port, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] v);
      cmd_t c;
      c.we = w; c.a = a; c.dat = v;
      if (port) pq1.push_back(c);
      else      pq0.push_back(c);
   endtask

   task automatic step();
      cmd_t h0, h1, c;
      rd_t  r;
      logic [1:0] mreq, mgnt;
      @(negedge clk);
      chk("ram_we", 32'(ram_we), 32'(m_we));
      chk("ram_addr", 32'(ram_addr), 32'(m_addr));
      chk("ram_d", 32'(ram_d), 32'(m_d));
      if (sb.size() > 0 && sb[0].due == cyc) begin
         chk("rvalid", 32'(rvalid), sb[0].p ? 32'd2 : 32'd1);
         chk("q", 32'(q), 32'(sb[0].dat));
         void'(sb.pop_front());
      end else begin
         chk("rvalid_idle", 32'(rvalid), 32'd0);
      end
      h0.we = 1'($urandom_range(0, 1)); h0.a = AW'($urandom); h0.dat = DW'($urandom);
      h1.we = 1'($urandom_range(0, 1)); h1.a = AW'($urandom); h1.dat = DW'($urandom);
      if (pq0.size() != 0) h0 = pq0[0];
      if (pq1.size() != 0) h1 = pq1[0];
      mreq = {pq1.size() != 0, pq0.size() != 0};
      req  = mreq;
      we   = {h1.we, h0.we};
      addr = {h1.a, h0.a};
      d    = {h1.dat, h0.dat};
      #1;
      mgnt = mreq;
      if (mreq == 2'b11) mgnt = (RR && mptr) ? 2'b10 : 2'b01;
      chk("gnt", 32'(gnt), 32'(mgnt));
      @(posedge clk);
      cyc++;
      m_we = 1'b0;
      if (mgnt != 2'b00) begin
         if (mgnt[1]) c = pq1.pop_front();
         else         c = pq0.pop_front();
         m_we   = c.we;
         m_addr = c.a;
         m_d    = c.dat;
         if (c.we) begin
            shadow[c.a] = c.dat;
         end else begin
            r.due = cyc + 1; r.p = mgnt[1]; r.dat = shadow[c.a];
            sb.push_back(r);
         end
         mptr = ~mgnt[1];
      end
   endtask

   task automatic run_until_idle(input int limit);
      int n;
      n = 0;
      while ((pq0.size() != 0 || pq1.size() != 0 || sb.size() != 0) && n < limit) begin
         step();
         n++;
      end
      if (n >= limit) chk("drain_timeout", 32'd1, 32'd0);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_ram_we", 32'(ram_we), 32'd0);
      chk("rst_ram_addr", 32'(ram_addr), 32'd0);
      chk("rst_ram_d", 32'(ram_d), 32'd0);
      chk("rst_rvalid", 32'(rvalid), 32'd0);
      pq0.delete(); pq1.delete(); sb.delete();
      m_we = 1'b0; m_addr = '0; m_d = '0; mptr = 1'b0;
      req = 2'b00;
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      total = 0; bad = 0; cyc = '0;
      mptr = 1'b0; m_we = 1'b0; m_addr = '0; m_d = '0;
      for (int i = 0; i < (1 << AW); i++) shadow[i] = '0;
      rst_n = 1'b0; req = 2'b11; we = 2'b00; addr = '0; d = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("init_gnt", 32'(gnt), 32'd0);
      chk("init_ram_we", 32'(ram_we), 32'd0);
      chk("init_ram_addr", 32'(ram_addr), 32'd0);
      chk("init_ram_d", 32'(ram_d), 32'd0);
      chk("init_rvalid", 32'(rvalid), 32'd0);
      req = 2'b00;
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Write then read-back on port 0, back to back.
      push_cmd(1'b0, 1'b1, 10'h010, 8'hA5);
      push_cmd(1'b0, 1'b0, 10'h010, 8'h00);
      run_until_idle(20);

      // Preload, contending writes from both ports, then idle.
      for (int i = 0; i < 6; i++) begin
         push_cmd(1'b0, 1'b1, AW'(32'h20 + i), DW'(32'h40 + i));
         push_cmd(1'b1, 1'b1, AW'(32'h30 + i), DW'(32'h80 + i));
      end
      run_until_idle(40);
      repeat (5) step();

      // Both ports streaming reads from reset.
      pulse_reset();
      for (int i = 0; i < 6; i++) begin
         push_cmd(1'b0, 1'b0, AW'(32'h20 + i), 8'h00);
         push_cmd(1'b1, 1'b0, AW'(32'h30 + i), 8'h00);
      end
      run_until_idle(40);

      // Read in flight when reset hits must never complete.
      push_cmd(1'b1, 1'b0, 10'h3FF, 8'h00);
      step();
      pulse_reset();
      repeat (4) step();

      // Random mixed traffic on a small address window.
      for (int n = 0; n < 400; n++) begin
         if (pq0.size() < 2 && $urandom_range(0, 2) != 0)
            push_cmd(1'b0, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom));
         if (pq1.size() < 2 && $urandom_range(0, 2) != 0)
            push_cmd(1'b1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom));
         step();
      end
      run_until_idle(40);
      repeat (3) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/spram_arbiter.md
SPRAM_ARBITER -- requirements
Module: spram_arbiter

Interface
REQ-001 SHALL have parameter aWidth, default 10: RAM address width.
REQ-002 SHALL have parameter dWidth, default 8: RAM data width.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req  input  2  access request per port; bit i = port i.
REQ-006 we  input  2  per-port write select; 1 = write, 0 = read; qualified by req.
REQ-007 addr  input  2*aWidth  per-port address; port i in bits [i*aWidth +: aWidth].
REQ-008 d  input  2*dWidth  per-port write data; port i in bits [i*dWidth +: dWidth].
REQ-009 gnt  output  2  one-hot grant; combinational; at most one bit high per cycle.
REQ-010 rvalid  output  2  read data valid for port i; registered.
REQ-011 q  output  dWidth  shared read data bus; combinational copy of ram_q.
REQ-012 ram_we  output  1  RAM write enable; registered.
REQ-013 ram_addr  output  aWidth  RAM address; registered.
REQ-014 ram_d  output  dWidth  RAM write data; registered.
REQ-015 ram_q  input  dWidth  RAM read data, one-cycle registered latency after ram_addr.

Function
REQ-016 SHALL accept at most one request per cycle; gnt[i] high in cycle N means port i's we/addr/d are captured at end of N.
REQ-017 Requesters SHALL hold req/we/addr/d stable until gnt; arbiter SHALL NOT check this.
REQ-018 gnt SHALL be 0 when req == 0; a single requester SHALL be granted the same cycle.
REQ-019 Stage 1 SHALL register captured command: ram_we/ram_addr/ram_d valid in cycle N+1; ram_we = 0 in any cycle with no captured write.
REQ-020 With no grant, ram_addr and ram_d SHALL hold previous values.
REQ-021 Stage 2 SHALL track read port id; granted read in cycle N SHALL assert rvalid[i] for exactly one cycle in N+2, with q = ram_q then.
REQ-022 Writes SHALL produce no rvalid; write-to-read same address back-to-back SHALL return new data (RAM write-first).
REQ-023 Sustained throughput SHALL be one access per cycle; reads from both ports SHALL pipeline without bubbles.
REQ-024 Arbitration state: 1-bit priority pointer ptr (port favoured on conflict).
REQ-025 Both ports requesting: grant port ptr; after any grant to port i, ptr SHALL become 1-i.
REQ-026 Single requester granted SHALL also update ptr per REQ-025.
REQ-027 rvalid SHALL never be high on both bits simultaneously.

Reset
REQ-028 On rst_n low, asynchronously: ram_we=0, ram_addr=0, ram_d=0, rvalid=0, stage valids=0, ptr=0.
REQ-029 gnt SHALL be 0 while rst_n low; reads in flight at reset SHALL be discarded (no rvalid after release).
REQ-030 First grant possible in the first cycle after rst_n deasserts.

Configuration
REQ-031 Macro SPRAM_ARB_RR_EN defined: round-robin per REQ-024..026.
REQ-032 SPRAM_ARB_RR_EN undefined: fixed priority, port 0 always wins conflicts; ptr register SHALL be absent; all other behaviour identical.

Verification
REQ-033 Port 0 write 0xA5 @0x010 cycle 1, port 0 read @0x010 cycle 2 -> gnt[0] cycles 1,2; ram_we=1 cycle 2; rvalid[0] cycle 4, q=0xA5.
REQ-034 Both ports read continuously 6 cycles from reset (RR build) -> gnt sequence 01,10,01,10,01,10; rvalid alternates from cycle 3; no bubbles.
REQ-035 Same stimulus, SPRAM_ARB_RR_EN undefined -> gnt[0] every cycle, gnt[1] only after req[0] drops.
REQ-036 Port 1 read @0x3FF granted, rst_n pulsed low next cycle -> rvalid stays 0; ram_we=0, ram_addr=0 immediately.
REQ-037 req=0 for 5 cycles after writes -> gnt=0, ram_we=0, ram_addr/ram_d unchanged, rvalid=0.
